// File: rtl/reg_3a_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_3a_pkg
// Description : Shared constants for the 3A control register block: the
//               register word map, the per-window field offsets and a helper
//               that produces the unity white-balance gain for a given
//               number of fraction bits.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_3a_pkg;

    // Register word addresses
    localparam int c_addr_int_en  = 'h00;
    localparam int c_addr_int_st  = 'h01;
    localparam int c_addr_gain_r  = 'h02;
    localparam int c_addr_gain_g  = 'h03;
    localparam int c_addr_gain_b  = 'h04;
    localparam int c_addr_commit  = 'h05;

    // Window k occupies words c_win_base + c_win_stride*k + field
    localparam int c_win_base     = 'h10;
    localparam int c_win_stride   = 4;

    localparam logic [1:0] c_fld_x_start = 2'd0;
    localparam logic [1:0] c_fld_width   = 2'd1;
    localparam logic [1:0] c_fld_y_start = 2'd2;
    localparam logic [1:0] c_fld_height  = 2'd3;

    // Unity gain is 1.0 in the fixed-point gain format
    function automatic int f_unity_gain(input int ratio);
        return 1 << ratio;
    endfunction

endpackage : reg_3a_pkg
`default_nettype wire

// File: rtl/reg_3a_aoi_clamp.sv
`default_nettype none
// ============================================================================
// Module      : reg_3a_aoi_clamp
// Description : Combinational clamp of one statistics window against the
//               active sensor image. Start is limited to dim-1 and the length
//               to the pixels remaining after the clamped start. A zero image
//               dimension collapses that axis of the window to zero.
// Ports       : i_x_start/i_width/i_y_start/i_height  staged window
//               i_sensor_width/i_sensor_height        active image size
//               o_x_start/o_width/o_y_start/o_height  clamped window
// Revision    : 1.0 - initial release
// ============================================================================
module reg_3a_aoi_clamp
    import reg_3a_pkg::*;
#(
    parameter int OFFSET_WIDTH = 12
) (
    input  logic [OFFSET_WIDTH-1:0] i_x_start,
    input  logic [OFFSET_WIDTH-1:0] i_width,
    input  logic [OFFSET_WIDTH-1:0] i_y_start,
    input  logic [OFFSET_WIDTH-1:0] i_height,
    input  logic [OFFSET_WIDTH-1:0] i_sensor_width,
    input  logic [OFFSET_WIDTH-1:0] i_sensor_height,
    output logic [OFFSET_WIDTH-1:0] o_x_start,
    output logic [OFFSET_WIDTH-1:0] o_width,
    output logic [OFFSET_WIDTH-1:0] o_y_start,
    output logic [OFFSET_WIDTH-1:0] o_height
);

    localparam int c_ew = OFFSET_WIDTH + 1;

    // Returns {clamped_start, clamped_len}, each one bit wider than a field
    // so that dim-1 and dim-start never wrap.
    function automatic logic [2*c_ew-1:0] f_clamp(
        input logic [OFFSET_WIDTH-1:0] start,
        input logic [OFFSET_WIDTH-1:0] len,
        input logic [OFFSET_WIDTH-1:0] dim
    );
        logic [c_ew-1:0] d;
        logic [c_ew-1:0] s;
        logic [c_ew-1:0] l;
        logic [c_ew-1:0] rem;
        d   = {1'b0, dim};
        s   = {1'b0, start};
        l   = {1'b0, len};
        rem = '0;
        if (d == '0) begin
            s = '0;
            l = '0;
        end else begin
            if (s > d - 1'b1) begin
                s = d - 1'b1;
            end
            rem = d - s;
            if (l > rem) begin
                l = rem;
            end
        end
        return {s, l};
    endfunction

    logic [2*c_ew-1:0] w_x_pair;
    logic [2*c_ew-1:0] w_y_pair;
    logic              w_unused_msb;

    assign w_x_pair  = f_clamp(i_x_start, i_width,  i_sensor_width);
    assign w_y_pair  = f_clamp(i_y_start, i_height, i_sensor_height);

    assign o_x_start = w_x_pair[c_ew +: OFFSET_WIDTH];
    assign o_width   = w_x_pair[0    +: OFFSET_WIDTH];
    assign o_y_start = w_y_pair[c_ew +: OFFSET_WIDTH];
    assign o_height  = w_y_pair[0    +: OFFSET_WIDTH];

    // Clamped results never exceed a field, so the guard bits are always zero
    assign w_unused_msb = ^{w_x_pair[2*c_ew-1], w_x_pair[c_ew-1],
                            w_y_pair[2*c_ew-1], w_y_pair[c_ew-1]};

endmodule : reg_3a_aoi_clamp
`default_nettype wire

// File: rtl/reg_3a_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reg_3a_ctrl
// Description : 3A (white balance / statistics window) control registers.
//               Bus writes land in staging registers; a commit arms a
//               transfer that copies staging to the active outputs on the
//               next frame-valid rising edge, with windows clamped to the
//               sensor image. Per-window statistics-done pulses set W1C
//               status bits that drive a maskable interrupt.
// Ports       : clk_sensor_pix, reset_n (sync, active low)
//               i_wr_en/i_rd_en/iv_addr/iv_wr_data -> ov_rd_data/o_rd_valid
//               i_fval, iv_sensor_width/height, iv_stat_done
//               ov_wb_gain_r/g/b, ov_aoi_* (window k at k*OFFSET_WIDTH),
//               o_interrupt
// Revision    : 1.0 - initial release
// ============================================================================
module reg_3a_ctrl
    import reg_3a_pkg::*;
#(
    parameter int AOI_NUM      = 2,
    parameter int OFFSET_WIDTH = 12,
    parameter int GAIN_WIDTH   = 11,
    parameter int WB_RATIO     = 8,
    parameter int REG_WD       = 32,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                            clk_sensor_pix,
    input  logic                            reset_n,
    input  logic                            i_wr_en,
    input  logic                            i_rd_en,
    input  logic [ADDR_WIDTH-1:0]           iv_addr,
    input  logic [REG_WD-1:0]               iv_wr_data,
    output logic [REG_WD-1:0]               ov_rd_data,
    output logic                            o_rd_valid,
    input  logic                            i_fval,
    input  logic [OFFSET_WIDTH-1:0]         iv_sensor_width,
    input  logic [OFFSET_WIDTH-1:0]         iv_sensor_height,
    input  logic [AOI_NUM-1:0]              iv_stat_done,
    output logic [GAIN_WIDTH-1:0]           ov_wb_gain_r,
    output logic [GAIN_WIDTH-1:0]           ov_wb_gain_g,
    output logic [GAIN_WIDTH-1:0]           ov_wb_gain_b,
    output logic [AOI_NUM*OFFSET_WIDTH-1:0] ov_aoi_x_start,
    output logic [AOI_NUM*OFFSET_WIDTH-1:0] ov_aoi_width,
    output logic [AOI_NUM*OFFSET_WIDTH-1:0] ov_aoi_y_start,
    output logic [AOI_NUM*OFFSET_WIDTH-1:0] ov_aoi_height,
    output logic                            o_interrupt
);

    localparam logic [GAIN_WIDTH-1:0] c_gain_unity = GAIN_WIDTH'(f_unity_gain(WB_RATIO));

    // Staging (bus-visible) registers
    logic [AOI_NUM-1:0]                    r_int_en;
    logic [AOI_NUM-1:0]                    r_int_status;
    logic [GAIN_WIDTH-1:0]                 r_stg_gain_r, r_stg_gain_g, r_stg_gain_b;
    logic [AOI_NUM-1:0][OFFSET_WIDTH-1:0]  r_stg_x, r_stg_w, r_stg_y, r_stg_h;
    logic                                  r_commit_pending;

    // Active registers
    logic [GAIN_WIDTH-1:0]                 r_gain_r, r_gain_g, r_gain_b;
    logic [AOI_NUM-1:0][OFFSET_WIDTH-1:0]  r_act_x, r_act_w, r_act_y, r_act_h;

    logic                                  r_fval_d;
    logic                                  r_fval_armed;
    logic                                  r_irq;
    logic                                  r_rd_valid;
    logic [REG_WD-1:0]                     r_rd_data;

    // Clamped view of the staging windows
    logic [AOI_NUM-1:0][OFFSET_WIDTH-1:0]  w_clp_x, w_clp_w, w_clp_y, w_clp_h;

    int                                    w_addr_int;
    logic [AOI_NUM-1:0]                    w_win_hit;
    logic [REG_WD-1:0]                     w_rd_mux;
    logic [AOI_NUM-1:0]                    w_w1c_mask;
    logic                                  w_commit_wr;
    logic                                  w_fval_rise;
    logic                                  w_xfer;
    logic                                  w_unused_wr;

    assign w_addr_int  = 32'(iv_addr);
    assign w_commit_wr = i_wr_en && (w_addr_int == c_addr_commit);
    assign w_w1c_mask  = (i_wr_en && (w_addr_int == c_addr_int_st)) ?
                         iv_wr_data[AOI_NUM-1:0] : '0;

    // A rise only counts once fval has been seen low since reset, so a reset
    // taken mid-frame does not treat the ongoing frame as a new one.
    assign w_fval_rise = i_fval && !r_fval_d && r_fval_armed;
    // A commit written in the rise cycle itself still transfers this frame
    assign w_xfer      = w_fval_rise && (r_commit_pending || w_commit_wr);

    // Upper data bits beyond each field are deliberately dropped
    assign w_unused_wr = ^iv_wr_data;

    always_comb begin
        w_win_hit = '0;
        for (int k = 0; k < AOI_NUM; k++) begin
            w_win_hit[k] = (w_addr_int >= c_win_base + c_win_stride*k) &&
                           (w_addr_int <  c_win_base + c_win_stride*(k+1));
        end
    end

    always_comb begin
        w_rd_mux = '0;
        if (w_addr_int == c_addr_int_en) begin
            w_rd_mux[AOI_NUM-1:0] = r_int_en;
        end else if (w_addr_int == c_addr_int_st) begin
            w_rd_mux[AOI_NUM-1:0] = r_int_status;
        end else if (w_addr_int == c_addr_gain_r) begin
            w_rd_mux[GAIN_WIDTH-1:0] = r_stg_gain_r;
        end else if (w_addr_int == c_addr_gain_g) begin
            w_rd_mux[GAIN_WIDTH-1:0] = r_stg_gain_g;
        end else if (w_addr_int == c_addr_gain_b) begin
            w_rd_mux[GAIN_WIDTH-1:0] = r_stg_gain_b;
        end
        for (int k = 0; k < AOI_NUM; k++) begin
            if (w_win_hit[k]) begin
                case (iv_addr[1:0])
                    c_fld_x_start: w_rd_mux[OFFSET_WIDTH-1:0] = r_stg_x[k];
                    c_fld_width:   w_rd_mux[OFFSET_WIDTH-1:0] = r_stg_w[k];
                    c_fld_y_start: w_rd_mux[OFFSET_WIDTH-1:0] = r_stg_y[k];
                    default:       w_rd_mux[OFFSET_WIDTH-1:0] = r_stg_h[k];
                endcase
            end
        end
    end

    generate
        for (genvar k = 0; k < AOI_NUM; k++) begin : g_aoi_clamp
            reg_3a_aoi_clamp #(
                .OFFSET_WIDTH (OFFSET_WIDTH)
            ) u_clamp (
                .i_x_start       (r_stg_x[k]),
                .i_width         (r_stg_w[k]),
                .i_y_start       (r_stg_y[k]),
                .i_height        (r_stg_h[k]),
                .i_sensor_width  (iv_sensor_width),
                .i_sensor_height (iv_sensor_height),
                .o_x_start       (w_clp_x[k]),
                .o_width         (w_clp_w[k]),
                .o_y_start       (w_clp_y[k]),
                .o_height        (w_clp_h[k])
            );
        end
    endgenerate

    always_ff @(posedge clk_sensor_pix) begin
        if (!reset_n) begin
            r_int_en         <= '0;
            r_int_status     <= '0;
            r_stg_gain_r     <= c_gain_unity;
            r_stg_gain_g     <= c_gain_unity;
            r_stg_gain_b     <= c_gain_unity;
            r_stg_x          <= '0;
            r_stg_w          <= '0;
            r_stg_y          <= '0;
            r_stg_h          <= '0;
            r_commit_pending <= 1'b0;
            r_gain_r         <= c_gain_unity;
            r_gain_g         <= c_gain_unity;
            r_gain_b         <= c_gain_unity;
            r_act_x          <= '0;
            r_act_w          <= '0;
            r_act_y          <= '0;
            r_act_h          <= '0;
            r_fval_d         <= 1'b0;
            r_fval_armed     <= 1'b0;
            r_irq            <= 1'b0;
            r_rd_valid       <= 1'b0;
            r_rd_data        <= '0;
        end else begin
            r_fval_d <= i_fval;
            if (!i_fval) begin
                r_fval_armed <= 1'b1;
            end

            if (i_wr_en) begin
                if (w_addr_int == c_addr_int_en) r_int_en     <= iv_wr_data[AOI_NUM-1:0];
                if (w_addr_int == c_addr_gain_r) r_stg_gain_r <= iv_wr_data[GAIN_WIDTH-1:0];
                if (w_addr_int == c_addr_gain_g) r_stg_gain_g <= iv_wr_data[GAIN_WIDTH-1:0];
                if (w_addr_int == c_addr_gain_b) r_stg_gain_b <= iv_wr_data[GAIN_WIDTH-1:0];
                for (int k = 0; k < AOI_NUM; k++) begin
                    if (w_win_hit[k]) begin
                        case (iv_addr[1:0])
                            c_fld_x_start: r_stg_x[k] <= iv_wr_data[OFFSET_WIDTH-1:0];
                            c_fld_width:   r_stg_w[k] <= iv_wr_data[OFFSET_WIDTH-1:0];
                            c_fld_y_start: r_stg_y[k] <= iv_wr_data[OFFSET_WIDTH-1:0];
                            default:       r_stg_h[k] <= iv_wr_data[OFFSET_WIDTH-1:0];
                        endcase
                    end
                end
            end

            // New done pulses override a coincident clear
            r_int_status <= (r_int_status & ~w_w1c_mask) | iv_stat_done;

            if (w_xfer) begin
                r_commit_pending <= 1'b0;
            end else if (w_commit_wr) begin
                r_commit_pending <= 1'b1;
            end

            // Transfer samples staging as it stood before this cycle's writes
            if (w_xfer) begin
                r_gain_r <= r_stg_gain_r;
                r_gain_g <= r_stg_gain_g;
                r_gain_b <= r_stg_gain_b;
                r_act_x  <= w_clp_x;
                r_act_w  <= w_clp_w;
                r_act_y  <= w_clp_y;
                r_act_h  <= w_clp_h;
            end

            r_irq      <= |(r_int_status & r_int_en);
            r_rd_valid <= i_rd_en;
            r_rd_data  <= i_rd_en ? w_rd_mux : '0;
        end
    end

    assign ov_rd_data     = r_rd_data;
    assign o_rd_valid     = r_rd_valid;
    assign ov_wb_gain_r   = r_gain_r;
    assign ov_wb_gain_g   = r_gain_g;
    assign ov_wb_gain_b   = r_gain_b;
    assign ov_aoi_x_start = r_act_x;
    assign ov_aoi_width   = r_act_w;
    assign ov_aoi_y_start = r_act_y;
    assign ov_aoi_height  = r_act_h;
    assign o_interrupt    = r_irq;

endmodule : reg_3a_ctrl
`default_nettype wire

// File: tb/tb_reg_3a_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_3a_ctrl
// Description : Self-checking bench for reg_3a_ctrl. A table of per-cycle
//               {inputs, expected outputs} records is applied in a loop,
//               followed by hand-written sequences for commit-on-edge,
//               reset mid-frame and zero sensor width.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_3a_ctrl;

    localparam int c_aoi = 2;
    localparam int c_ow  = 12;
    localparam int c_gw  = 11;
    localparam int c_rw  = 32;
    localparam int c_aw  = 8;

    typedef struct {
        logic                   wr;
        logic                   rd;
        logic [c_aw-1:0]        addr;
        logic [c_rw-1:0]        wd;
        logic                   fval;
        logic [c_aoi-1:0]       done;
        logic                   rv;
        logic [c_rw-1:0]        rdata;
        logic                   irq;
        logic [c_aoi*c_ow-1:0]  x, w, y, h;
        logic [c_gw-1:0]        gr, gg, gb;
    } vec_t;

    logic                   clk_sensor_pix = 1'b0;
    logic                   reset_n        = 1'b0;
    logic                   i_wr_en        = 1'b0;
    logic                   i_rd_en        = 1'b0;
    logic [c_aw-1:0]        iv_addr        = '0;
    logic [c_rw-1:0]        iv_wr_data     = '0;
    logic [c_rw-1:0]        ov_rd_data;
    logic                   o_rd_valid;
    logic                   i_fval         = 1'b0;
    logic [c_ow-1:0]        iv_sensor_width  = 12'd1920;
    logic [c_ow-1:0]        iv_sensor_height = 12'd1080;
    logic [c_aoi-1:0]       iv_stat_done   = '0;
    logic [c_gw-1:0]        ov_wb_gain_r, ov_wb_gain_g, ov_wb_gain_b;
    logic [c_aoi*c_ow-1:0]  ov_aoi_x_start, ov_aoi_width, ov_aoi_y_start, ov_aoi_height;
    logic                   o_interrupt;

    int n_vec = 0;
    int n_err = 0;

    // Expected active state, updated by hand at each transfer point
    logic [c_aoi*c_ow-1:0]  e_x, e_w, e_y, e_h;
    logic [c_gw-1:0]        e_gr, e_gg, e_gb;

    vec_t tbl[$];

    always #5 clk_sensor_pix = ~clk_sensor_pix;

    reg_3a_ctrl dut (
        .clk_sensor_pix   (clk_sensor_pix),
        .reset_n          (reset_n),
        .i_wr_en          (i_wr_en),
        .i_rd_en          (i_rd_en),
        .iv_addr          (iv_addr),
        .iv_wr_data       (iv_wr_data),
        .ov_rd_data       (ov_rd_data),
        .o_rd_valid       (o_rd_valid),
        .i_fval           (i_fval),
        .iv_sensor_width  (iv_sensor_width),
        .iv_sensor_height (iv_sensor_height),
        .iv_stat_done     (iv_stat_done),
        .ov_wb_gain_r     (ov_wb_gain_r),
        .ov_wb_gain_g     (ov_wb_gain_g),
        .ov_wb_gain_b     (ov_wb_gain_b),
        .ov_aoi_x_start   (ov_aoi_x_start),
        .ov_aoi_width     (ov_aoi_width),
        .ov_aoi_y_start   (ov_aoi_y_start),
        .ov_aoi_height    (ov_aoi_height),
        .o_interrupt      (o_interrupt)
    );

    function automatic logic [c_aoi*c_ow-1:0] flat(input int w1, input int w0);
        logic [c_ow-1:0] a1, a0;
        a1 = c_ow'(w1);
        a0 = c_ow'(w0);
        return {a1, a0};
    endfunction

    function automatic vec_t mkv(input logic wr, input logic rd, input int addr,
                                 input int wd, input logic fval, input int done,
                                 input logic rv, input int rdata, input logic irq);
        vec_t v;
        v.wr = wr;  v.rd = rd;  v.addr = c_aw'(addr);  v.wd = c_rw'(wd);
        v.fval = fval;  v.done = c_aoi'(done);
        v.rv = rv;  v.rdata = c_rw'(rdata);  v.irq = irq;
        v.x = e_x;  v.w = e_w;  v.y = e_y;  v.h = e_h;
        v.gr = e_gr;  v.gg = e_gg;  v.gb = e_gb;
        return v;
    endfunction

    function automatic vec_t wrv(input int addr, input int wd, input logic fval, input logic irq);
        return mkv(1'b1, 1'b0, addr, wd, fval, 0, 1'b0, 0, irq);
    endfunction

    function automatic vec_t rdv(input int addr, input logic fval, input int exp, input logic irq);
        return mkv(1'b0, 1'b1, addr, 0, fval, 0, 1'b1, exp, irq);
    endfunction

    function automatic vec_t idv(input logic fval, input int done, input logic irq);
        return mkv(1'b0, 1'b0, 0, 0, fval, done, 1'b0, 0, irq);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL vec%0d %s: got 0x%0h, expected 0x%0h", n_vec, name, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        @(negedge clk_sensor_pix);
        i_wr_en      = v.wr;
        i_rd_en      = v.rd;
        iv_addr      = v.addr;
        iv_wr_data   = v.wd;
        i_fval       = v.fval;
        iv_stat_done = v.done;
        @(posedge clk_sensor_pix);
        #1;
        n_vec++;
        chk("rd_valid", 32'(o_rd_valid), 32'(v.rv));
        if (v.rv) chk("rd_data", ov_rd_data, v.rdata);
        chk("interrupt", 32'(o_interrupt), 32'(v.irq));
        chk("aoi_x_start", 32'(ov_aoi_x_start), 32'(v.x));
        chk("aoi_width",   32'(ov_aoi_width),   32'(v.w));
        chk("aoi_y_start", 32'(ov_aoi_y_start), 32'(v.y));
        chk("aoi_height",  32'(ov_aoi_height),  32'(v.h));
        chk("gain_r", 32'(ov_wb_gain_r), 32'(v.gr));
        chk("gain_g", 32'(ov_wb_gain_g), 32'(v.gg));
        chk("gain_b", 32'(ov_wb_gain_b), 32'(v.gb));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        e_x = '0;  e_w = '0;  e_y = '0;  e_h = '0;
        e_gr = 11'h100;  e_gg = 11'h100;  e_gb = 11'h100;

        // ---------------- table: reset values and gain reads ----------------
        tbl.push_back(idv(1'b0, 0, 1'b0));
        tbl.push_back(rdv('h02, 1'b0, 'h100, 1'b0));
        tbl.push_back(rdv('h03, 1'b0, 'h100, 1'b0));
        tbl.push_back(rdv('h04, 1'b0, 'h100, 1'b0));
        tbl.push_back(idv(1'b0, 0, 1'b0));
        // window 0 staging, readback, fval rise without commit
        tbl.push_back(wrv('h10, 100, 1'b0, 1'b0));
        tbl.push_back(wrv('h11, 200, 1'b0, 1'b0));
        tbl.push_back(wrv('h12, 50,  1'b0, 1'b0));
        tbl.push_back(wrv('h13, 60,  1'b0, 1'b0));
        tbl.push_back(rdv('h11, 1'b0, 200, 1'b0));
        tbl.push_back(idv(1'b1, 0, 1'b0));
        tbl.push_back(idv(1'b0, 0, 1'b0));
        // commit, then the rise transfers window 0 (window 1 still zero)
        tbl.push_back(wrv('h05, 1, 1'b0, 1'b0));
        e_x = flat(0, 100);  e_w = flat(0, 200);  e_y = flat(0, 50);  e_h = flat(0, 60);
        tbl.push_back(idv(1'b1, 0, 1'b0));
        tbl.push_back(idv(1'b1, 0, 1'b0));
        // window 1 beyond the image, gains incl. truncated write
        tbl.push_back(wrv('h14, 1900, 1'b1, 1'b0));
        tbl.push_back(wrv('h15, 100,  1'b1, 1'b0));
        tbl.push_back(wrv('h16, 2000, 1'b1, 1'b0));
        tbl.push_back(wrv('h17, 10,   1'b1, 1'b0));
        tbl.push_back(wrv('h02, 'h123, 1'b1, 1'b0));
        tbl.push_back(wrv('h03, 32'hFFFF_F955, 1'b1, 1'b0));
        tbl.push_back(rdv('h03, 1'b1, 'h155, 1'b0));
        tbl.push_back(wrv('h05, 0, 1'b0, 1'b0));
        e_x = flat(1900, 100);  e_w = flat(20, 200);  e_y = flat(1079, 50);  e_h = flat(1, 60);
        e_gr = 11'h123;  e_gg = 11'h155;
        tbl.push_back(idv(1'b1, 0, 1'b0));
        // staging change without commit never reaches the outputs
        tbl.push_back(wrv('h11, 999, 1'b1, 1'b0));
        tbl.push_back(idv(1'b0, 0, 1'b0));
        tbl.push_back(idv(1'b1, 0, 1'b0));
        // interrupt: enable window 0, done pulse, W1C races
        tbl.push_back(wrv('h00, 1, 1'b1, 1'b0));
        tbl.push_back(idv(1'b1, 1, 1'b0));
        tbl.push_back(idv(1'b1, 0, 1'b1));
        tbl.push_back(rdv('h01, 1'b1, 1, 1'b1));
        tbl.push_back(mkv(1'b1, 1'b0, 'h01, 1, 1'b1, 1, 1'b0, 0, 1'b1));
        tbl.push_back(rdv('h01, 1'b1, 1, 1'b1));
        tbl.push_back(wrv('h01, 1, 1'b1, 1'b1));
        tbl.push_back(idv(1'b1, 0, 1'b0));
        // masked window 1, then enabling it
        tbl.push_back(idv(1'b1, 2, 1'b0));
        tbl.push_back(idv(1'b1, 0, 1'b0));
        tbl.push_back(rdv('h01, 1'b1, 2, 1'b0));
        tbl.push_back(rdv('h00, 1'b1, 1, 1'b0));
        tbl.push_back(wrv('h00, 3, 1'b1, 1'b0));
        tbl.push_back(idv(1'b1, 0, 1'b1));
        tbl.push_back(wrv('h01, 2, 1'b1, 1'b1));
        tbl.push_back(idv(1'b1, 0, 1'b0));
        // unmapped / commit reads return zero, unmapped write ignored
        tbl.push_back(rdv('h05, 1'b1, 0, 1'b0));
        tbl.push_back(rdv('h18, 1'b1, 0, 1'b0));
        tbl.push_back(wrv('h18, 'hABC, 1'b1, 1'b0));
        tbl.push_back(rdv('h14, 1'b1, 1900, 1'b0));

        repeat (3) @(posedge clk_sensor_pix);
        #1 reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply_vec(tbl[i]);
        end

        // ---------- commit written in the fval rising cycle ----------
        apply_vec(idv(1'b0, 0, 1'b0));
        e_w = flat(20, 999);
        apply_vec(wrv('h05, 0, 1'b1, 1'b0));
        apply_vec(wrv('h10, 500, 1'b1, 1'b0));
        apply_vec(idv(1'b0, 0, 1'b0));
        apply_vec(idv(1'b1, 0, 1'b0));

        // ---------- reset mid-frame with a commit pending ----------
        apply_vec(wrv('h02, 'h055, 1'b1, 1'b0));
        apply_vec(wrv('h05, 0, 1'b1, 1'b0));
        reset_n = 1'b0;
        e_x = '0;  e_w = '0;  e_y = '0;  e_h = '0;
        e_gr = 11'h100;  e_gg = 11'h100;  e_gb = 11'h100;
        apply_vec(idv(1'b1, 0, 1'b0));
        reset_n = 1'b1;
        apply_vec(wrv('h10, 7, 1'b1, 1'b0));
        apply_vec(idv(1'b0, 0, 1'b0));
        apply_vec(idv(1'b1, 0, 1'b0));
        apply_vec(rdv('h02, 1'b1, 'h100, 1'b0));

        // ---------- zero sensor width collapses the x axis ----------
        apply_vec(wrv('h11, 5,  1'b1, 1'b0));
        apply_vec(wrv('h12, 30, 1'b1, 1'b0));
        apply_vec(wrv('h13, 40, 1'b1, 1'b0));
        iv_sensor_width = '0;
        apply_vec(wrv('h05, 0, 1'b1, 1'b0));
        apply_vec(idv(1'b0, 0, 1'b0));
        e_y = flat(0, 30);  e_h = flat(0, 40);
        apply_vec(idv(1'b1, 0, 1'b0));
        iv_sensor_width = 12'd1920;
        apply_vec(idv(1'b1, 0, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_reg_3a_ctrl
`default_nettype wire
